// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline definitions: control-bundle field layout, bubble encoding
// and default bundle widths for each inter-stage boundary.
package pipe_stage_reg_pkg;

    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMTOREG = 1;
    localparam int CTRL_LINK     = 2;
    localparam int CTRL_HALT     = 3;
    localparam int CTRL_WREG_LSB = 4;
    localparam int CTRL_WREG_W   = 3;
    localparam int CTRL_MEMWRITE = 7;

    localparam int PIPE_DATA_W = 48;
    localparam int PIPE_CTRL_W = 8;

    // A bubble clears every side-effect bit (RegWrite, MemWrite, Halt).
    localparam logic [PIPE_CTRL_W-1:0] PIPE_CTRL_NOP = 8'h00;

    typedef enum logic [1:0] {
        BND_IF_ID,
        BND_ID_EX,
        BND_EX_MEM,
        BND_MEM_WB
    } stage_bnd_e;

    // IF/ID only carries instruction + PC+2; later boundaries pack three words.
    function automatic int data_w_for(stage_bnd_e bnd);
        return (bnd == BND_IF_ID) ? 32 : PIPE_DATA_W;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle seen by one pipeline stage register: upstream valid/ready
// with data+ctrl, downstream valid/ready with data+ctrl, and fill level.
interface pipe_stage_reg_if
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int CTRL_W = PIPE_CTRL_W
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [1:0]        occupancy;

    modport master (
        output in_valid, in_data, in_ctrl, out_ready,
        input  in_ready, out_valid, out_data, out_ctrl, occupancy
    );

    modport slave (
        input  in_valid, in_data, in_ctrl, out_ready,
        output in_ready, out_valid, out_data, out_ctrl, occupancy
    );
endinterface

// File: rtl/pipe_stage_reg_entry.sv
// One held pipeline entry: data + ctrl + valid, with clear taking priority
// over load. A cleared entry parks its ctrl at the bubble value.
module pipe_entry
    import pipe_stage_reg_pkg::*;
#(
    parameter int                DATA_W   = PIPE_DATA_W,
    parameter int                CTRL_W   = PIPE_CTRL_W,
    parameter logic [CTRL_W-1:0] CTRL_NOP = CTRL_W'(PIPE_CTRL_NOP)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0] ctrl_o
);
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        if (clear_i) begin
            valid_d = 1'b0;
            ctrl_d  = CTRL_NOP;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            ctrl_d  = ctrl_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= CTRL_NOP;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign ctrl_o  = ctrl_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// Stall-able, flushable pipeline stage register. SKID=1 adds a second entry so
// in_ready comes straight from a flop; SKID=0 is the classic single register.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int                DATA_W   = PIPE_DATA_W,
    parameter int                CTRL_W   = PIPE_CTRL_W,
    parameter logic [CTRL_W-1:0] CTRL_NOP = CTRL_W'(PIPE_CTRL_NOP),
    parameter int                SKID     = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    pipe_stage_reg_if.slave  bus
);
    logic              main_v, skid_v;
    logic [DATA_W-1:0] main_data, main_data_d;
    logic [CTRL_W-1:0] main_ctrl, main_ctrl_d;
    logic              main_load, main_clear;
    logic              in_ready_w, accept, emit;

    assign emit   = main_v & bus.out_ready;
    assign accept = bus.in_valid & in_ready_w;

    pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_NOP(CTRL_NOP)) u_main (
        .clk     (clk),
        .rst     (rst),
        .load_i  (main_load),
        .clear_i (main_clear),
        .data_i  (main_data_d),
        .ctrl_i  (main_ctrl_d),
        .valid_o (main_v),
        .data_o  (main_data),
        .ctrl_o  (main_ctrl)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic              skid_load, skid_clear;
            logic [DATA_W-1:0] skid_data;
            logic [CTRL_W-1:0] skid_ctrl;

            pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_NOP(CTRL_NOP)) u_skid (
                .clk     (clk),
                .rst     (rst),
                .load_i  (skid_load),
                .clear_i (skid_clear),
                .data_i  (bus.in_data),
                .ctrl_i  (bus.in_ctrl),
                .valid_o (skid_v),
                .data_o  (skid_data),
                .ctrl_o  (skid_ctrl)
            );

            // While the skid entry is occupied in_ready is low, so main refills
            // from skid on emit and never from the input in that case.
            assign in_ready_w  = ~skid_v;
            assign skid_load   = ~flush & accept & main_v & ~emit;
            assign skid_clear  = flush | (skid_v & emit);
            assign main_load   = ~flush & ((skid_v & emit) | (accept & (~main_v | emit)));
            assign main_clear  = flush | (emit & ~skid_v & ~accept);
            assign main_data_d = skid_v ? skid_data : bus.in_data;
            assign main_ctrl_d = skid_v ? skid_ctrl : bus.in_ctrl;
        end else begin : g_single
            assign skid_v      = 1'b0;
            assign in_ready_w  = bus.out_ready | ~main_v;
            assign main_load   = ~flush & accept;
            assign main_clear  = flush | (emit & ~accept);
            assign main_data_d = bus.in_data;
            assign main_ctrl_d = bus.in_ctrl;
        end
    endgenerate

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = main_v;
    assign bus.out_data  = main_data;
    assign bus.out_ctrl  = main_v ? main_ctrl : CTRL_NOP;
    assign bus.occupancy = {main_v & skid_v, main_v ^ skid_v};
endmodule
